mem_access_ctrl: RTL and testbench

//  Initiator side of the data-RAM re/we handshake: takes one load/store request from the CPU datapath,

---
 rtl/mem_access_ctrl_pkg.sv | 28 ++
 rtl/mem_lane_merge.sv | 33 +++
 rtl/mem_access_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the data-RAM access controller: access sizes, FSM states
// and the RAM geometry defaults used when the build does not supply them.
`ifndef MEM_RAM_WIDTH
`define MEM_RAM_WIDTH 12
`endif
`ifndef MEM_RAM_SIZE
`define MEM_RAM_SIZE 4096
`endif

package mem_access_ctrl_pkg;

  localparam logic [1:0] MACC_SZ_BYTE = 2'd0;
  localparam logic [1:0] MACC_SZ_HALF = 2'd1;
  localparam logic [1:0] MACC_SZ_WORD = 2'd2;

  localparam logic [2:0] MACC_IDLE   = 3'd0;
  localparam logic [2:0] MACC_RD     = 3'd1;
  localparam logic [2:0] MACC_RMW_RD = 3'd2;
  localparam logic [2:0] MACC_WR     = 3'd3;
  localparam logic [2:0] MACC_DONE   = 3'd4;
  localparam logic [2:0] MACC_ERR    = 3'd5;

  // Size code 3 is an alias of word, so only byte and half need a merge.
  function automatic logic is_subword(input logic [1:0] size);
    return (size == MACC_SZ_BYTE) || (size == MACC_SZ_HALF);
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane logic shared by the store read-modify-write merge and the
// load extract/extend path. Purely combinational.
module mem_lane_merge
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  always_comb begin
    o_merged = i_wdata;
    o_load   = i_rdata;
    case (i_size)
      MACC_SZ_BYTE: begin
        o_merged = {i_rdata[31:8], i_wdata[7:0]};
        o_load   = {{24{i_signed & i_rdata[7]}}, i_rdata[7:0]};
      end
      MACC_SZ_HALF: begin
        o_merged = {i_rdata[31:16], i_wdata[15:0]};
        o_load   = {{16{i_signed & i_rdata[15]}}, i_rdata[15:0]};
      end
      default: begin
        o_merged = i_wdata;
        o_load   = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-RAM re/we handshake for one CPU load/store at a time.
// Define MEM_ACC_TIMEOUT_EN to abort accesses whose *_finished never arrives.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W    = `MEM_RAM_WIDTH,
  parameter int MEM_SIZE  = `MEM_RAM_SIZE,
  parameter int TO_CYCLES = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              re,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [31:0]       read_data,
  input  logic              read_finished,
  output logic              we,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  input  logic              write_finished
);

`ifdef MEM_ACC_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic [2:0]        r_state;
  logic              r_busy;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic              r_re;
  logic [ADDR_W-1:0] r_read_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_write_addr;
  logic [31:0]       r_write_data;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [4:0]        r_cnt;

  logic [31:0]       w_merged;
  logic [31:0]       w_load;
  logic [32:0]       w_addr_end;
  logic              w_oob;
  logic              w_accept;
  logic              w_to_hit;

  // Widened so the last-byte address cannot wrap at the top of the port range.
  assign w_addr_end = 33'(req_addr) + 33'd3;
  assign w_oob      = (w_addr_end >= 33'(MEM_SIZE));
  assign w_accept   = req && !read_finished && !write_finished;
  assign w_to_hit   = TO_EN && (r_cnt == 5'(TO_CYCLES - 1));

  mem_lane_merge u_lane (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_rdata  (read_data),
    .i_wdata  (r_wdata),
    .o_merged (w_merged),
    .o_load   (w_load)
  );

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_state      <= MACC_IDLE;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_re         <= 1'b0;
      r_read_addr  <= '0;
      r_we         <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= 32'd0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_cnt        <= 5'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        MACC_IDLE: begin
          if (w_accept) begin
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
            if (w_oob) begin
              r_state      <= MACC_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (!req_we) begin
              r_state     <= MACC_RD;
              r_re        <= 1'b1;
              r_read_addr <= req_addr;
            end else if (is_subword(req_size)) begin
              r_state     <= MACC_RMW_RD;
              r_re        <= 1'b1;
              r_read_addr <= req_addr;
            end else begin
              r_state      <= MACC_WR;
              r_we         <= 1'b1;
              r_write_addr <= req_addr;
              r_write_data <= req_wdata;
            end
          end
        end
        MACC_RD, MACC_RMW_RD: begin
          if (read_finished) begin
            r_re  <= 1'b0;
            r_cnt <= 5'd0;
            if (r_state == MACC_RD) begin
              r_resp_rdata <= w_load;
              r_resp_valid <= 1'b1;
              r_state      <= MACC_DONE;
            end else begin
              r_we         <= 1'b1;
              r_write_addr <= r_addr;
              r_write_data <= w_merged;
              r_state      <= MACC_WR;
            end
          end else if (w_to_hit) begin
            // Abandoning here also skips the write half of an RMW.
            r_re         <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_state      <= MACC_ERR;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        MACC_WR: begin
          if (write_finished) begin
            r_we         <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= MACC_DONE;
          end else if (w_to_hit) begin
            r_we         <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_state      <= MACC_ERR;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        MACC_DONE, MACC_ERR: begin
          r_state <= MACC_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= MACC_IDLE;
          r_busy  <= 1'b0;
          r_re    <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign re         = r_re;
  assign read_addr  = r_read_addr;
  assign we         = r_we;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-array reference model predicts each
// response at issue time; a monitor process compares whenever resp_valid pulses.
module tb_mem_access_ctrl;

  localparam int AW = 10;
  localparam int MS = 1024;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          clrn;
  logic          req;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          busy;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          re;
  logic [AW-1:0] read_addr;
  logic [31:0]   read_data;
  logic          read_finished;
  logic          we;
  logic [AW-1:0] write_addr;
  logic [31:0]   write_data;
  logic          write_finished;

  typedef struct {
    bit          is_load;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [MS];
  logic [7:0]  ref_mem [MS];
  int          checks = 0;
  int          failures = 0;
  int          lat = 0;
  bit          hang = 1'b0;
  int          rcnt;
  int          wcnt;
  int          we_pulses = 0;
  bit          seen_rw = 1'b0;
  logic        we_d = 1'b0;
  logic        poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0] poke_data = 32'd0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(AW), .MEM_SIZE(MS), .TO_CYCLES(TO)) dut (
    .clk(clk), .clrn(clrn), .req(req), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .re(re), .read_addr(read_addr), .read_data(read_data), .read_finished(read_finished),
    .we(we), .write_addr(write_addr), .write_data(write_data), .write_finished(write_finished)
  );

  assign read_data = {mem[read_addr + AW'(3)], mem[read_addr + AW'(2)],
                      mem[read_addr + AW'(1)], mem[read_addr]};

  // RAM model: finishes each access 'lat' cycles after seeing re/we; 'hang' stalls it.
  always @(posedge clk) begin
    if (poke_en) begin
      for (int i = 0; i < 4; i++) mem[poke_addr + AW'(i)] <= poke_data[8*i +: 8];
    end
    if (clrn) begin
      read_finished  <= 1'b0;
      write_finished <= 1'b0;
      rcnt <= 0;
      wcnt <= 0;
    end else begin
      if (re && !hang) begin
        if (!read_finished) begin
          if (rcnt >= lat) begin read_finished <= 1'b1; rcnt <= 0; end
          else rcnt <= rcnt + 1;
        end
      end else begin
        read_finished <= 1'b0;
        rcnt <= 0;
      end
      if (we && !hang) begin
        if (!write_finished) begin
          if (wcnt >= lat) begin
            write_finished <= 1'b1;
            wcnt <= 0;
            for (int i = 0; i < 4; i++) mem[write_addr + AW'(i)] <= write_data[8*i +: 8];
          end else wcnt <= wcnt + 1;
        end
      end else begin
        write_finished <= 1'b0;
        wcnt <= 0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: plain byte-array semantics, no notion of RMW or FSM states.
  function automatic exp_t model(bit w, logic [1:0] sz, bit sg, int a, logic [31:0] wd);
    exp_t e;
    int nb;
    logic [31:0] word;
    logic [31:0] mask;
    e.is_load = !w;
    e.err = 1'b0;
    e.rdata = 32'd0;
    if (a + 3 >= MS) begin
      e.err = 1'b1;
      return e;
    end
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (w) begin
      for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      word = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      if (nb == 4) e.rdata = word;
      else begin
        mask = (32'd1 << (8*nb)) - 32'd1;
        e.rdata = word & mask;
        if (sg && e.rdata[8*nb-1]) e.rdata = e.rdata | ~mask;
      end
    end
    return e;
  endfunction

  task automatic poke_word(input int a, input logic [31:0] w);
    poke_en = 1'b1;
    poke_addr = AW'(a);
    poke_data = w;
    for (int i = 0; i < 4; i++) ref_mem[(a + i) % MS] = w[8*i +: 8];
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(busy == 1'b0 && !read_finished && !write_finished) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL wait_ready budget expired busy=%b", busy);
    end
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit sg, input int a,
                       input logic [31:0] wd, input bit use_model);
    wait_ready();
    req = 1'b1; req_we = w; req_size = sz; req_signed = sg;
    req_addr = AW'(a); req_wdata = wd;
    if (use_model) sb.push_back(model(w, sz, sg, a, wd));
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_resp(output int k, input int budget);
    k = 1;
    while (!resp_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!resp_valid) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout actual=no_resp required=resp_within_%0d", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_re"}, 32'(re), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_read_addr"}, 32'(read_addr), 32'd0);
    check({tag, "_write_addr"}, 32'(write_addr), 32'd0);
    check({tag, "_write_data"}, write_data, 32'd0);
  endtask

  // Monitor: pops the scoreboard on every response and watches re/we exclusivity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("re_we_exclusive", 32'(re & we), 32'd0);
      if (re || we) seen_rw = 1'b1;
      if (we && !we_d) we_pulses++;
      we_d = we;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=resp_valid required=no_resp");
        end else begin
          e = sb.pop_front();
          check("resp_err", 32'(resp_err), 32'(e.err));
          if (e.is_load && !e.err) check("resp_rdata", resp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int a;
    int wp0;
    clrn = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < MS; i += 4) poke_word(i, $urandom);

    // Load word with 3-cycle latency.
    lat = 0;
    poke_word(32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);
    wait_resp(k, 20);
    check("ld_word_lat", 32'(k), 32'd3);
    check("ld_word_val", resp_rdata, 32'hDEADBEEF);

    // Signed and unsigned byte loads.
    poke_word(32'h10, 32'h000000F0);
    issue(1'b0, 2'd0, 1'b1, 32'h10, 32'd0, 1'b1);
    wait_resp(k, 20);
    check("ld_byte_s", resp_rdata, 32'hFFFFFFF0);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, 1'b1);
    wait_resp(k, 20);
    check("ld_byte_u", resp_rdata, 32'h000000F0);

    // Byte store as RMW with one write pulse and 5-cycle latency.
    poke_word(32'h20, 32'h11223344);
    wp0 = we_pulses;
    issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h000000AB, 1'b1);
    wait_resp(k, 20);
    check("st_byte_lat", 32'(k), 32'd5);
    @(negedge clk);
    check("st_byte_we_pulses", 32'(we_pulses - wp0), 32'd1);
    check("st_byte_ram", {mem[32'h23], mem[32'h22], mem[32'h21], mem[32'h20]}, 32'h112233AB);

    // Word store latency.
    issue(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 1'b1);
    wait_resp(k, 20);
    check("st_word_lat", 32'(k), 32'd3);

    // Out-of-range load: error on the next cycle with no RAM traffic.
    wait_ready();
    seen_rw = 1'b0;
    issue(1'b0, 2'd2, 1'b0, MS - 2, 32'd0, 1'b1);
    wait_resp(k, 20);
    check("oob_lat", 32'(k), 32'd1);
    check("oob_err", 32'(resp_err), 32'd1);
    repeat (2) @(negedge clk);
    check("oob_no_ram", 32'(seen_rw), 32'd0);

    // RAM never finishes.
    hang = 1'b1;
`ifdef MEM_ACC_TIMEOUT_EN
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0);
    sb.push_back('{is_load: 1'b1, err: 1'b1, rdata: 32'd0});
    wait_resp(k, 60);
    check("to_lat_in_range", 32'(k >= TO && k <= TO + 2), 32'd1);
    check("to_re_dropped", 32'(re), 32'd0);
    hang = 1'b0;
`else
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0);
    repeat (40) @(negedge clk);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_re", 32'(re), 32'd1);
    clrn = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    hang = 1'b0;
`endif

    // Reset in the middle of an RMW, then a normal word store and readback.
    issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h00000055, 1'b0);
    check("rmw_in_flight_re", 32'(re), 32'd1);
    clrn = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    check_reset_outputs("abort");
    issue(1'b1, 2'd2, 1'b0, 32'h50, 32'h0BADF00D, 1'b1);
    wait_resp(k, 20);
    check("post_abort_lat", 32'(k), 32'd3);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b1);
    wait_resp(k, 20);
    check("abort_no_write", resp_rdata, 32'h112233AB);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      wait_ready();
      lat = $urandom_range(0, 3);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(MS - 6, MS - 1) : $urandom_range(0, MS - 1);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'b1);
    end
    wait_ready();
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
